meoww_stim_seq: RTL and testbench
=================================

Name: meoww_stim_seq

Overview:
- Upstream stimulus sequencer for the 3-input combinational gate stage: drives its a, b, c inputs through all 8 combinations.
- Steps either on a debounced push-button (manual mode) or on a dwell timer (auto mode), so the board LEDs on x/y can be checked one vector at a time.
- Outputs a 1-cycle strobe per applied vector and counts completed sweeps.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive stable samples needed to accept a button level change (>=1).
- DWELL_CYCLES, 100_000_000, clock cycles each vector is held in auto mode (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_step  input  1  raw, asynchronous step push-button.
- auto_en  input  1  1 = auto mode, 0 = manual mode; synchronous to clk.
- hold  input  1  auto mode only: freezes the dwell timer while high.
- a  output  1  stimulus bit, vec_idx[2].
- b  output  1  stimulus bit, vec_idx[1].
- c  output  1  stimulus bit, vec_idx[0].
- vec_idx  output  3  current vector index; {a,b,c} == vec_idx.
- vec_valid  output  1  high for exactly the first cycle in which a new vector is on a/b/c.
- sweep_done  output  1  1-cycle pulse, coincident with vec_valid, when vec_idx wraps 7->0.
- sweep_cnt  output  8  completed sweeps; saturates at 255.

Behaviour:
- Reset (async, immediate): vec_idx=0, a=b=c=0, vec_valid=0, sweep_done=0, sweep_cnt=0, state=IDLE; dwell counter, debounce counter, sync flops and debounced level all 0.
- All outputs are registered. No combinational path from any input to any output.
- Debounce:
  - 2-FF synchronizer on btn_step produces s2.
  - When s2 != stable, deb_cnt increments. On the edge where deb_cnt==DEB_CYCLES-1, stable<=s2 and deb_cnt<=0.
  - When s2 == stable, deb_cnt<=0.
  - step_p is a registered 1-cycle pulse on a 0->1 transition of stable.
  - Timing: if btn_step is first sampled high at edge 0 and stays high, a/b/c update at edge DEB_CYCLES+3.
  - Glitches shorter than DEB_CYCLES cycles are ignored. Release generates no step.
- FSM states:
  - IDLE: lasts exactly one cycle after reset release. At that edge vec_valid<=1 (vector 0), then go to AUTO if auto_en=1, else MAN.
  - MAN: step_p -> vec_idx<=vec_idx+1 (mod 8) and vec_valid<=1 at the same edge. auto_en=1 -> AUTO with dwell counter cleared.
  - AUTO: dwell increments each cycle while hold=0. At dwell==DWELL_CYCLES-1 with hold=0: dwell<=0, vec_idx advances, vec_valid<=1. Entering at edge E means the first advance is at edge E+DWELL_CYCLES. step_p is ignored. auto_en=0 -> MAN with dwell cleared.
- Mode change keeps vec_idx. A mode change in the same cycle as a step or dwell expiry: the mode change wins and the advance is dropped.
- hold: no effect in MAN. In AUTO, hold=1 holds dwell at its current value (including DWELL_CYCLES-1), and no advance occurs until hold is released.
- Wrap: an advance from 7 gives 0, asserts sweep_done with vec_valid, and increments sweep_cnt unless it is 255.
- Reset mid-sweep: immediate return to vector 0. A button held through reset produces exactly one step after debounce, because stable resets to 0.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Test Plan (DEB_CYCLES=4, DWELL_CYCLES=5):
1. Reset release with auto_en=0 -> vec_valid=1 for cycle 1 only, a/b/c=000, state MAN, no further change with btn_step=0.
2. btn_step high from edge 0 for 20 cycles -> abc=001 at edge 7, vec_valid single pulse; 3-cycle btn_step glitch -> no change.
3. auto_en=1 held from reset -> abc steps 000,001,...,111,000 every 5 cycles; sweep_done and vec_valid coincide at the 111->000 step; sweep_cnt=1.
4. AUTO with hold=1 asserted for 12 cycles when dwell==4 -> no advance during hold; advance on the first edge after hold drops.
5. auto_en toggled 1->0 in the same cycle as dwell expiry at vec_idx=3 -> vec_idx stays 3, no vec_valid, state MAN.
6. Force 256 sweeps in AUTO -> sweep_cnt stays 255; async rst mid-dwell -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/meoww_stim_seq.sv
// Stimulus sequencer: sweeps {a,b,c} through all 8 vectors, stepped by a
// debounced push-button (manual) or a dwell timer (auto).
module meoww_stim_seq #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       auto_en,
  input  logic       hold,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       vec_valid,
  output logic       sweep_done,
  output logic [7:0] sweep_cnt
);

  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAN  = 2'd1;
  localparam logic [1:0] ST_AUTO = 2'd2;

  logic               s1, s2, stable, stable_d, step_p;
  logic [DEB_W-1:0]   deb_cnt;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         state;
  logic               adv;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Button synchronizer, debounce and rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      step_p   <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      s1       <= btn_step;
      s2       <= s1;
      stable_d <= stable;
      step_p   <= stable & ~stable_d;
      if (s2 != stable) begin
        if (deb_cnt == DEB_LAST) begin
          stable  <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A pending mode change suppresses any advance in the same cycle
  always_comb begin
    adv = 1'b0;
    if (state == ST_MAN && !auto_en && step_p)
      adv = 1'b1;
    else if (state == ST_AUTO && auto_en && !hold && dwell == DWELL_LAST)
      adv = 1'b1;
  end

  // Mode FSM, dwell timer and vector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dwell      <= '0;
      vec_idx    <= 3'd0;
      vec_valid  <= 1'b0;
      sweep_done <= 1'b0;
      sweep_cnt  <= 8'd0;
    end else begin
      vec_valid  <= (state == ST_IDLE) || adv;
      sweep_done <= adv && (vec_idx == 3'd7);
      if (adv) begin
        vec_idx <= vec_idx + 3'd1;
        if (vec_idx == 3'd7)
          sweep_cnt <= sat_inc8(sweep_cnt);
      end

      if (state != ST_AUTO || !auto_en)
        dwell <= '0;
      else if (!hold)
        dwell <= (dwell == DWELL_LAST) ? '0 : dwell + DWELL_W'(1);

      case (state)
        ST_IDLE: state <= auto_en ? ST_AUTO : ST_MAN;
        ST_MAN:  if (auto_en) state <= ST_AUTO;
        ST_AUTO: if (!auto_en) state <= ST_MAN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a = vec_idx[2];
  assign b = vec_idx[1];
  assign c = vec_idx[0];

endmodule

// File: tb/tb_meoww_stim_seq.sv
// Bench for meoww_stim_seq: directed phases plus randomized button/mode/hold
// activity, checked every cycle against a sweep-count reference model.
module tb_meoww_stim_seq;

  localparam int DEB   = 4;
  localparam int DWELL = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b0;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic       a, b, c, vec_valid, sweep_done;
  logic [2:0] vec_idx;
  logic [7:0] sweep_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: total vectors advanced since reset, debounce by window
  int total;
  bit started, mode_auto, stable_m, r1, r2, exp_valid, exp_done;
  int remain;
  int samples[$];

  meoww_stim_seq #(.DEB_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .auto_en(auto_en), .hold(hold),
    .a(a), .b(b), .c(c), .vec_idx(vec_idx), .vec_valid(vec_valid),
    .sweep_done(sweep_done), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    total = 0; started = 0; mode_auto = 0; stable_m = 0;
    r1 = 0; r2 = 0; exp_valid = 0; exp_done = 0; remain = DWELL;
    samples.delete();
  endtask

  task automatic advance();
    total++;
    exp_valid = 1;
    exp_done = (total % 8 == 0);
  endtask

  task automatic model_step();
    bit step, flip;
    int k, j, v;
    step = r2; r2 = r1; r1 = 0;
    samples.push_back(int'(btn_step));
    k = samples.size() - 1;
    // level accepted once the synchronized button disagrees for DEB edges running
    flip = 1;
    for (int i = 0; i < DEB; i++) begin
      j = k - 2 - i;
      v = (j < 0) ? 0 : samples[j];
      if (v != (stable_m ? 0 : 1)) flip = 0;
    end
    if (flip) begin
      stable_m = !stable_m;
      r1 = stable_m;
    end
    exp_valid = 0; exp_done = 0;
    if (!started) begin
      started = 1; exp_valid = 1; mode_auto = auto_en; remain = DWELL;
    end else if (!mode_auto) begin
      if (auto_en) begin mode_auto = 1; remain = DWELL; end
      else if (step) advance();
    end else begin
      if (!auto_en) mode_auto = 0;
      else if (!hold) begin
        remain--;
        if (remain == 0) begin advance(); remain = DWELL; end
      end
    end
  endtask

  task automatic check_all();
    int exp_idx, exp_cnt;
    exp_idx = total % 8;
    exp_cnt = (total / 8 > 255) ? 255 : total / 8;
    check("vec_idx", 32'(vec_idx), 32'(exp_idx));
    check("abc", 32'({a, b, c}), 32'(exp_idx));
    check("vec_valid", 32'(vec_valid), 32'(exp_valid));
    check("sweep_done", 32'(sweep_done), 32'(exp_done));
    check("sweep_cnt", 32'(sweep_cnt), 32'(exp_cnt));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    bit reached;
    int run;
    model_reset();

    // 1: reset release in manual mode
    #1 check_all();
    cyc(2);
    rst = 1'b0;
    cyc(6);

    // 2: held button steps once; short glitch ignored
    btn_step = 1'b1; cyc(20);
    btn_step = 1'b0; cyc(10);
    btn_step = 1'b1; cyc(3);
    btn_step = 1'b0; cyc(10);
    check("manual_idx_after_glitch", 32'(vec_idx), 32'd1);

    // 3: auto mode from reset, full sweep
    auto_en = 1'b1;
    do_reset();
    cyc(45);
    check("sweep_cnt_after_one", 32'(sweep_cnt), 32'd1);

    // 4: hold while dwell timer is at its last count
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      cyc(1);
      if (mode_auto && remain == 1) reached = 1;
    end
    check("reach_hold_point", 32'(reached), 32'd1);
    hold = 1'b1; cyc(12);
    hold = 1'b0; cyc(1);
    cyc(4);

    // 5: mode change coincident with dwell expiry at vector 3
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      cyc(1);
      if (mode_auto && remain == 1 && total % 8 == 3) reached = 1;
    end
    check("reach_idx3_expiry", 32'(reached), 32'd1);
    auto_en = 1'b0; cyc(1);
    check("mode_change_keeps_idx", 32'(vec_idx), 32'd3);
    cyc(8);
    btn_step = 1'b1; cyc(10);
    btn_step = 1'b0; cyc(8);

    // 6: saturation, then async reset mid-dwell
    auto_en = 1'b1;
    cyc(256 * 40 + 20);
    check("sweep_cnt_saturated", 32'(sweep_cnt), 32'd255);
    cyc(2);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // button held through reset yields exactly one step
    auto_en = 1'b0;
    btn_step = 1'b1; cyc(3);
    do_reset();
    cyc(20);
    btn_step = 1'b0; cyc(10);

    // randomized button runs, mode toggles and hold
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        btn_step = ~btn_step;
        run = $urandom_range(1, 7);
      end
      run--;
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      hold = ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
